baccarat_fsm: RTL and testbench

- Control FSM for a Baccarat table.
- Sequences dealing of the player and dealer cards by pulsing one-hot load strobes to the card datapath.
- Applies standard third-card (tableau) rules using the hand scores and the player's third card.
- Drives the player-win and dealer-win lights at the end of the hand. A tie lights both.

---
 rtl/baccarat_fsm.sv | 117 +++++++++++
 tb/tb_baccarat_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_fsm.sv
// Baccarat table control: deals P1,D1,P2,D2 then applies tableau third-card rules; lights in DONE.
// Latency: one state per slow_clock edge, loads registered; lights combinational from live scores in DONE.
// No backpressure: the datapath must accept a load strobe every cycle. Checkers under BACCARAT_FSM_ASSERT_EN.
module baccarat_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] dscore,
  input  logic [3:0] pscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    D1   = 3'd2,
    P2   = 3'd3,
    D2   = 3'd4,
    P3   = 3'd5,
    D3   = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   in_done;

  // Face cards and tens count as zero toward the dealer's drawing decision.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] card);
    logic [3:0] v;
    logic       draw;
    v    = (card <= 4'd9) ? card : 4'd0;
    draw = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v == 4'd6) || (v == 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = P1;
      P1:   state_nxt = D1;
      D1:   state_nxt = P2;
      P2:   state_nxt = D2;
      D2: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8))
          state_nxt = DONE;
        else if (pscore <= 4'd5)
          state_nxt = P3;
        else if (dscore <= 4'd5)
          state_nxt = D3;
        else
          state_nxt = DONE;
      end
      P3:   state_nxt = dealer_draws(dscore, pcard3) ? D3 : DONE;
      D3:   state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free Moore outputs.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      in_done     <= 1'b0;
      load_pcard1 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard3 <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_done     <= (state_nxt == DONE);
      load_pcard1 <= (state_nxt == P1);
      load_dcard1 <= (state_nxt == D1);
      load_pcard2 <= (state_nxt == P2);
      load_dcard2 <= (state_nxt == D2);
      load_pcard3 <= (state_nxt == P3);
      load_dcard3 <= (state_nxt == D3);
    end
  end

  // Lights follow the live scores so a late score update is shown without a clock edge.
  assign player_win_light = in_done && (pscore >= dscore);
  assign dealer_win_light = in_done && (dscore >= pscore);

`ifdef BACCARAT_FSM_ASSERT_EN
  always @(posedge slow_clock) begin
    if (resetb) begin
      assert ($onehot0({load_pcard1, load_dcard1, load_pcard2,
                        load_dcard2, load_pcard3, load_dcard3}))
        else $error("baccarat_fsm: load strobes not one-hot-or-zero");
      assert (in_done || (!player_win_light && !dealer_win_light))
        else $error("baccarat_fsm: light active outside DONE");
      assert (state inside {IDLE, P1, D1, P2, D2, P3, D3, DONE})
        else $error("baccarat_fsm: unencoded state");
    end
  end
`endif

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for baccarat_fsm: deal sequence, tableau branches, lights and async reset.
module tb_baccarat_fsm;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] dscore;
  logic [3:0] pscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  int checks;
  int failures;

  baccarat_fsm dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .dscore           (dscore),
    .pscore           (pscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  // {pc1, dc1, pc2, dc2, pc3, dc3, player_light, dealer_light}
  function automatic logic [7:0] outs();
    return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
            load_pcard3, load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic apply_reset();
    resetb = 1'b0;
    #3;
    resetb = 1'b1;
  endtask

  // Reset then clock up to D2; scores are set before the D2 exit edge.
  task automatic deal_to_d2(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3);
    apply_reset();
    pscore = p;
    dscore = d;
    pcard3 = c3;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    pscore = 4'd9;
    dscore = 4'd9;
    pcard3 = 4'd0;
    #2;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", outs(), 8'b0000_0000);
    end
    resetb = 1'b1;
  endtask

  task automatic test_sequence();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'b1000_0000;
    exp_seq[1] = 8'b0100_0000;
    exp_seq[2] = 8'b0010_0000;
    exp_seq[3] = 8'b0001_0000;
    apply_reset();
    pscore = 4'd9;
    dscore = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL seq_step%0d got=%b exp=%b", i, outs(), exp_seq[i]);
      end
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0011) begin
      failures++;
      $display("FAIL seq_done_tie got=%b exp=%b", outs(), 8'b0000_0011);
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0011) begin
      failures++;
      $display("FAIL done_holds got=%b exp=%b", outs(), 8'b0000_0011);
    end
    pscore = 4'd3;
    #1;
    checks++;
    if (outs() !== 8'b0000_0001) begin
      failures++;
      $display("FAIL done_live_score got=%b exp=%b", outs(), 8'b0000_0001);
    end
  endtask

  task automatic test_natural();
    deal_to_d2(4'd9, 4'd8, 4'd0);
    tick();
    checks++;
    if (outs() !== 8'b0000_0010) begin
      failures++;
      $display("FAIL natural_player got=%b exp=%b", outs(), 8'b0000_0010);
    end
    deal_to_d2(4'd2, 4'd8, 4'd0);
    tick();
    checks++;
    if (outs() !== 8'b0000_0001) begin
      failures++;
      $display("FAIL natural_dealer got=%b exp=%b", outs(), 8'b0000_0001);
    end
  endtask

  task automatic test_player_stands();
    deal_to_d2(4'd6, 4'd5, 4'd0);
    tick();
    checks++;
    if (outs() !== 8'b0000_0100) begin
      failures++;
      $display("FAIL stand_dealer_draws got=%b exp=%b", outs(), 8'b0000_0100);
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0010) begin
      failures++;
      $display("FAIL stand_player_win got=%b exp=%b", outs(), 8'b0000_0010);
    end
    deal_to_d2(4'd7, 4'd6, 4'd0);
    tick();
    checks++;
    if (outs() !== 8'b0000_0010) begin
      failures++;
      $display("FAIL both_stand got=%b exp=%b", outs(), 8'b0000_0010);
    end
  endtask

  task automatic test_player_draws();
    deal_to_d2(4'd5, 4'd7, 4'd0);
    tick();
    checks++;
    if (outs() !== 8'b0000_1000) begin
      failures++;
      $display("FAIL draw_p3 got=%b exp=%b", outs(), 8'b0000_1000);
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0001) begin
      failures++;
      $display("FAIL draw_dealer_win got=%b exp=%b", outs(), 8'b0000_0001);
    end
  endtask

  task automatic test_dealer_sweep();
    logic [3:0] d;
    logic [1:0] exp_l;
    for (int i = 0; i <= 6; i++) begin
      d = i[3:0];
      deal_to_d2(4'd3, d, 4'd6);
      tick();
      tick();
      checks++;
      if (outs() !== 8'b0000_0100) begin
        failures++;
        $display("FAIL sweep_d%0d_draw got=%b exp=%b", i, outs(), 8'b0000_0100);
      end
      tick();
      exp_l = {(4'd3 >= d), (d >= 4'd3)};
      checks++;
      if (outs() !== {6'b0, exp_l}) begin
        failures++;
        $display("FAIL sweep_d%0d_lights got=%b exp=%b", i, outs(), {6'b0, exp_l});
      end
    end
    deal_to_d2(4'd3, 4'd3, 4'd8);
    tick();
    tick();
    checks++;
    if (outs() !== 8'b0000_0011) begin
      failures++;
      $display("FAIL d3_card8_stand got=%b exp=%b", outs(), 8'b0000_0011);
    end
    deal_to_d2(4'd3, 4'd6, 4'd2);
    tick();
    tick();
    checks++;
    if (outs() !== 8'b0000_0001) begin
      failures++;
      $display("FAIL d6_card2_stand got=%b exp=%b", outs(), 8'b0000_0001);
    end
    deal_to_d2(4'd3, 4'd4, 4'd12);
    tick();
    tick();
    checks++;
    if (outs() !== 8'b0000_0001) begin
      failures++;
      $display("FAIL d4_face_stand got=%b exp=%b", outs(), 8'b0000_0001);
    end
    deal_to_d2(4'd3, 4'd3, 4'd11);
    tick();
    tick();
    checks++;
    if (outs() !== 8'b0000_0100) begin
      failures++;
      $display("FAIL d3_face_draw got=%b exp=%b", outs(), 8'b0000_0100);
    end
  endtask

  task automatic test_tie();
    deal_to_d2(4'd5, 4'd5, 4'd6);
    tick();
    checks++;
    if (outs() !== 8'b0000_1000) begin
      failures++;
      $display("FAIL tie_p3 got=%b exp=%b", outs(), 8'b0000_1000);
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0100) begin
      failures++;
      $display("FAIL tie_d3 got=%b exp=%b", outs(), 8'b0000_0100);
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0011) begin
      failures++;
      $display("FAIL tie_lights got=%b exp=%b", outs(), 8'b0000_0011);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick();
    tick();
    checks++;
    if (outs() !== 8'b0100_0000) begin
      failures++;
      $display("FAIL mid_in_d1 got=%b exp=%b", outs(), 8'b0100_0000);
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL mid_async_clear got=%b exp=%b", outs(), 8'b0000_0000);
    end
    #2;
    resetb = 1'b1;
    tick();
    checks++;
    if (outs() !== 8'b1000_0000) begin
      failures++;
      $display("FAIL mid_restart got=%b exp=%b", outs(), 8'b1000_0000);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetb   = 1'b0;
    pscore   = 4'd0;
    dscore   = 4'd0;
    pcard3   = 4'd0;
    #1;
    test_reset();
    test_sequence();
    test_natural();
    test_player_stands();
    test_player_draws();
    test_dealer_sweep();
    test_tie();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
